// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: handshake and datapath-select bundle for aes_round_ctrl.
// AES_CTRL_DECRYPT_EN adds the decrypt request and dec_mode indication.
interface aes_round_ctrl_if #(
  parameter int STEPS_PER_ROUND = 3,
  parameter int STEP_W = (STEPS_PER_ROUND > 2) ? $clog2(STEPS_PER_ROUND) : 1
);
  logic in_valid, in_ready, out_valid, out_ready, load_en, last_round, enable_ks, busy;
  logic [1:0] key_mode;
  logic [STEP_W-1:0] round_step;
  logic [3:0] round_index;
`ifdef AES_CTRL_DECRYPT_EN
  logic decrypt, dec_mode;
  modport master(output in_valid, key_mode, out_ready, decrypt,
                 input in_ready, out_valid, load_en, round_step, round_index, last_round, enable_ks, busy, dec_mode);
  modport slave(input in_valid, key_mode, out_ready, decrypt,
                output in_ready, out_valid, load_en, round_step, round_index, last_round, enable_ks, busy, dec_mode);
`else
  modport master(output in_valid, key_mode, out_ready,
                 input in_ready, out_valid, load_en, round_step, round_index, last_round, enable_ks, busy);
  modport slave(input in_valid, key_mode, out_ready,
                output in_ready, out_valid, load_en, round_step, round_index, last_round, enable_ks, busy);
`endif
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round/step sequencer for the multicycle AES datapath (AES-128/192/256).
// Optional AES_CTRL_DECRYPT_EN: round_index counts down from nr-1 for decryption.
module aes_round_ctrl #(
  parameter int STEPS_PER_ROUND = 3,
  parameter int STEP_W = (STEPS_PER_ROUND > 2) ? $clog2(STEPS_PER_ROUND) : 1
) (
  input logic clk,
  input logic rst_n,
  aes_round_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_ROUND - 1);
  localparam logic [STEP_W-1:0] STEP_FIN = STEP_W'(STEPS_PER_ROUND - 2);
  state_t state;
  logic [STEP_W-1:0] step;
  logic [3:0] idx, nr_q, nr_new, final_idx, idx_init, idx_next;
  logic last, at_end, load;
`ifdef AES_CTRL_DECRYPT_EN
  logic dec_q;
  assign final_idx = dec_q ? 4'd0 : nr_q - 4'd1;
  assign idx_init = bus.decrypt ? nr_new - 4'd1 : 4'd0;
  assign idx_next = dec_q ? idx - 4'd1 : idx + 4'd1;
  assign bus.dec_mode = dec_q;
`else
  assign final_idx = nr_q - 4'd1;
  assign idx_init = 4'd0;
  assign idx_next = idx + 4'd1;
`endif
  // reserved key_mode 3 falls back to the AES-128 round count
  assign nr_new = bus.key_mode == 2'd1 ? 4'd12 : bus.key_mode == 2'd2 ? 4'd14 : 4'd10;
  assign last = state == ROUND && idx == final_idx;
  assign at_end = state == ROUND && step == (last ? STEP_FIN : STEP_LAST);
  assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
  assign load = bus.in_valid && bus.in_ready;
  assign bus.load_en = load;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state == ROUND;
  assign bus.last_round = last;
  assign bus.enable_ks = at_end;
  assign bus.round_step = step;
  assign bus.round_index = idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      idx <= '0;
      nr_q <= 4'd10;
`ifdef AES_CTRL_DECRYPT_EN
      dec_q <= 1'b0;
`endif
    end else
      case (state)
        IDLE, DONE:
          if (load) begin
            state <= ROUND;
            step <= '0;
            idx <= idx_init;
            nr_q <= nr_new;
`ifdef AES_CTRL_DECRYPT_EN
            dec_q <= bus.decrypt;
`endif
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
            step <= '0;
            idx <= '0;
          end
        ROUND:
          if (step > STEP_LAST) begin
            state <= IDLE;
            step <= '0;
            idx <= '0;
          end else if (at_end && last) state <= DONE;
          else if (at_end) begin
            step <= '0;
            idx <= idx_next;
          end else step <= step + 1'b1;
        default: begin
          state <= IDLE;
          step <= '0;
          idx <= '0;
        end
      endcase
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed vectors for aes_round_ctrl with STEPS_PER_ROUND=3.
// Define AES_CTRL_DECRYPT_EN to also exercise the decrypt sequence.
module tb_aes_round_ctrl;
  localparam int SPR = 3;
  logic clk = 0, rst_n = 1;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  aes_round_ctrl_if #(.STEPS_PER_ROUND(SPR)) bus();
  aes_round_ctrl #(.STEPS_PER_ROUND(SPR)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // handshake in the current cycle, then follow the block until out_valid
  task automatic run_block(input logic [1:0] km, input int nr, input bit dec, input string tag);
    int c, ks, lr, bad_seq, bad_ks, e_idx, e_step;
    bit fin;
    bus.in_valid = 1;
    bus.key_mode = km;
`ifdef AES_CTRL_DECRYPT_EN
    bus.decrypt = dec;
`endif
    #1;
    chk({tag, " load_en"}, 32'(bus.load_en), 1);
    tick;
    bus.in_valid = 0;
    bus.key_mode = ~km;
`ifdef AES_CTRL_DECRYPT_EN
    bus.decrypt = ~dec;
`endif
    c = 1; ks = 0; lr = 0; bad_seq = 0; bad_ks = 0;
    while (!bus.out_valid && c <= nr * SPR + 5) begin
      e_idx = (c - 1) / SPR;
      e_step = (c - 1) % SPR;
      fin = e_idx == nr - 1;
      if (dec) e_idx = nr - 1 - e_idx;
      if (int'(bus.round_index) != e_idx || int'(bus.round_step) != e_step || !bus.busy ||
          bus.in_ready || bus.last_round != fin) bad_seq++;
      if (bus.enable_ks != (e_step == SPR - 1 || (fin && e_step == SPR - 2))) bad_ks++;
      ks += int'(bus.enable_ks);
      lr += int'(bus.last_round);
      tick;
      c++;
    end
    chk({tag, " latency"}, c, nr * SPR);
    chk({tag, " seq errs"}, bad_seq, 0);
    chk({tag, " ks pos errs"}, bad_ks, 0);
    chk({tag, " ks count"}, ks, nr);
    chk({tag, " last_round cycles"}, lr, SPR - 1);
    chk({tag, " final idx"}, 32'(bus.round_index), dec ? 0 : nr - 1);
    chk({tag, " final step"}, 32'(bus.round_step), SPR - 2);
  endtask

  task automatic done_exit(input string tag);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 1);
    bus.out_ready = 1;
    bus.in_valid = 0;
    #1;
    chk({tag, " in_ready done"}, 32'(bus.in_ready), 1);
    tick;
    chk({tag, " idle out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, " idle busy"}, 32'(bus.busy), 0);
    chk({tag, " idle idx"}, 32'(bus.round_index), 0);
    chk({tag, " idle step"}, 32'(bus.round_step), 0);
    chk({tag, " idle in_ready"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    int bad;
    bus.in_valid = 0;
    bus.key_mode = 0;
    bus.out_ready = 1;
`ifdef AES_CTRL_DECRYPT_EN
    bus.decrypt = 0;
`endif
    #1 rst_n = 0;
    #10;
    chk("rst in_ready", 32'(bus.in_ready), 1);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst load_en", 32'(bus.load_en), 0);
    chk("rst enable_ks", 32'(bus.enable_ks), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst last_round", 32'(bus.last_round), 0);
    chk("rst idx", 32'(bus.round_index), 0);
    chk("rst step", 32'(bus.round_step), 0);
    rst_n = 1;
    tick;
    run_block(2'd0, 10, 0, "aes128"); done_exit("aes128");
    run_block(2'd2, 14, 0, "aes256"); done_exit("aes256");
    run_block(2'd1, 12, 0, "aes192"); done_exit("aes192");
    // backpressure: result must stay frozen while out_ready is low
    bus.out_ready = 0;
    run_block(2'd0, 10, 0, "bp");
    bad = 0;
    bus.in_valid = 1;
    repeat (5) begin
      #1;
      if (!bus.out_valid || bus.round_index != 4'd9 || int'(bus.round_step) != 1 || bus.in_ready || bus.load_en) bad++;
      tick;
    end
    chk("bp hold errs", bad, 0);
    done_exit("bp");
    // back-to-back: second handshake lands in the first DONE cycle
    run_block(2'd0, 10, 0, "b2b1");
    chk("b2b out_valid", 32'(bus.out_valid), 1);
    run_block(2'd0, 10, 0, "b2b2");
    done_exit("b2b");
    // asynchronous reset during round 5
    bus.in_valid = 1;
    bus.key_mode = 0;
    tick;
    bus.in_valid = 0;
    repeat (5 * SPR) tick;
    chk("mid idx", 32'(bus.round_index), 5);
    rst_n = 0;
    #1;
    chk("mid rst busy", 32'(bus.busy), 0);
    chk("mid rst out_valid", 32'(bus.out_valid), 0);
    chk("mid rst idx", 32'(bus.round_index), 0);
    chk("mid rst step", 32'(bus.round_step), 0);
    chk("mid rst enable_ks", 32'(bus.enable_ks), 0);
    chk("mid rst in_ready", 32'(bus.in_ready), 1);
    tick;
    rst_n = 1;
    tick;
    run_block(2'd3, 10, 0, "km3"); done_exit("km3");
`ifdef AES_CTRL_DECRYPT_EN
    run_block(2'd0, 10, 1, "dec128");
    chk("dec dec_mode", 32'(bus.dec_mode), 1);
    done_exit("dec128");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
